// File: rtl/l2_flatten_pkg.sv
// Shared constants and types for the L2 flatten stage.
package l2_flatten_pkg;

    localparam int DW_DEF = 20;
    localparam int AW_DEF = 12;

    localparam logic [2:0] CSEL_NONE    = 3'b000;
    localparam logic [2:0] CSEL_L0      = 3'b001;
    localparam logic [2:0] CSEL_L1_BASE = 3'b011;
    localparam logic [2:0] CSEL_L2      = 3'b101;

    typedef enum logic [2:0] {
        IDLE,
        RD,
        CAP,
        WR,
        DONE
    } state_t;

endpackage

// File: rtl/flatten_addr_gen.sv
// Element/channel counters for the flatten walk plus combinational L1 read
// and interleaved L2 write addresses.
module flatten_addr_gen #(
    parameter int N_CH     = 2,
    parameter int CH_DEPTH = 1024,
    parameter int AW       = 12
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          clr,
    input  logic          adv,
    output logic          ch,
    output logic          last,
    output logic [AW-1:0] rd_addr,
    output logic [AW-1:0] wr_addr
);

    localparam int IW = (CH_DEPTH > 1) ? $clog2(CH_DEPTH) : 1;

    logic [IW-1:0] idx;
    logic          ch_last;

    // With a single channel every step is the channel wrap.
    assign ch_last = (N_CH == 1) ? 1'b1 : ch;
    assign last    = ch_last && (idx == IW'(CH_DEPTH - 1));
    assign rd_addr = AW'(idx);

    // Interleaving is a concat of idx and ch, so no multiplier is needed.
    generate
        if (N_CH == 2) begin : g_two_ch
            assign wr_addr = AW'({idx, ch});
        end else begin : g_one_ch
            assign wr_addr = AW'(idx);
        end
    endgenerate

    // Channel steps fastest; idx moves on when the channel wraps.
    always_ff @(posedge clk) begin
        if (!reset || clr) begin
            idx <= '0;
            ch  <= 1'b0;
        end else if (adv) begin
            if (ch_last) begin
                ch  <= 1'b0;
                idx <= idx + IW'(1);
            end else begin
                ch  <= 1'b1;
            end
        end
    end

endmodule

// File: rtl/l2_flatten.sv
// Copies the pooled L1 channel maps into L2 as one interleaved vector,
// L2[idx*N_CH+ch] = L1_ch[idx], three cycles (read/capture/write) per word.
module l2_flatten
    import l2_flatten_pkg::*;
#(
    parameter int N_CH     = 2,
    parameter int CH_DEPTH = 1024,
    parameter int AW       = AW_DEF,
    parameter int DW       = DW_DEF
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          start,
    output logic          busy,
    output logic          done,
    output logic          crd,
    output logic [AW-1:0] caddr_rd,
    input  logic [DW-1:0] cdata_rd,
    output logic          cwr,
    output logic [AW-1:0] caddr_wr,
    output logic [DW-1:0] cdata_wr,
    output logic [2:0]    csel
);

    state_t        state;
    logic          ch;
    logic          last;
    logic          fin;
    logic [AW-1:0] rd_addr;
    logic [AW-1:0] wr_addr;

    // Counters step as the write address is latched, so by the end of WR
    // they already point at the next element for the following RD.
    flatten_addr_gen #(
        .N_CH    (N_CH),
        .CH_DEPTH(CH_DEPTH),
        .AW      (AW)
    ) u_addr (
        .clk    (clk),
        .reset  (reset),
        .clr    (state == DONE),
        .adv    (state == CAP),
        .ch     (ch),
        .last   (last),
        .rd_addr(rd_addr),
        .wr_addr(wr_addr)
    );

    // Control FSM; every port is a register. cdata_wr doubles as the hold
    // register, and fin remembers whether the element in flight is the last.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state    <= IDLE;
            busy     <= 1'b0;
            done     <= 1'b0;
            crd      <= 1'b0;
            cwr      <= 1'b0;
            caddr_rd <= '0;
            caddr_wr <= '0;
            cdata_wr <= '0;
            csel     <= CSEL_NONE;
            fin      <= 1'b0;
        end else begin
            done <= 1'b0;
            crd  <= 1'b0;
            cwr  <= 1'b0;
            case (state)
                IDLE: begin
                    csel <= CSEL_NONE;
                    if (start) begin
                        state    <= RD;
                        busy     <= 1'b1;
                        crd      <= 1'b1;
                        csel     <= CSEL_L1_BASE + {2'b00, ch};
                        caddr_rd <= rd_addr;
                    end
                end
                RD: begin
                    state <= CAP;
                end
                CAP: begin
                    state    <= WR;
                    cdata_wr <= cdata_rd;
                    cwr      <= 1'b1;
                    csel     <= CSEL_L2;
                    caddr_wr <= wr_addr;
                    fin      <= last;
                end
                WR: begin
                    if (fin) begin
                        state <= DONE;
                        done  <= 1'b1;
                        csel  <= CSEL_NONE;
                    end else begin
                        state    <= RD;
                        crd      <= 1'b1;
                        csel     <= CSEL_L1_BASE + {2'b00, ch};
                        caddr_rd <= rd_addr;
                    end
                end
                DONE: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                    fin   <= 1'b0;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_l2_flatten.sv
// Bench for l2_flatten: memory models, a protocol monitor, a table of
// spot values, random data checked against an interleave model, and
// hand sequences for reset/start corner cases.
module tb_l2_flatten;

    localparam int AW = 12;
    localparam int DW = 20;

    logic          clk = 1'b0;
    logic          reset, start, start1;
    logic          busy, done, crd, cwr;
    logic [AW-1:0] caddr_rd, caddr_wr;
    logic [DW-1:0] cdata_rd, cdata_wr;
    logic [2:0]    csel;
    logic          busy1, done1, crd1, cwr1;
    logic [AW-1:0] caddr_rd1, caddr_wr1;
    logic [DW-1:0] cdata_rd1, cdata_wr1;
    logic [2:0]    csel1;

    always #5 clk = ~clk;

    l2_flatten #(.N_CH(2), .CH_DEPTH(1024), .AW(AW), .DW(DW)) dut (
        .clk(clk), .reset(reset), .start(start), .busy(busy), .done(done),
        .crd(crd), .caddr_rd(caddr_rd), .cdata_rd(cdata_rd), .cwr(cwr),
        .caddr_wr(caddr_wr), .cdata_wr(cdata_wr), .csel(csel)
    );

    l2_flatten #(.N_CH(1), .CH_DEPTH(16), .AW(AW), .DW(DW)) dut1 (
        .clk(clk), .reset(reset), .start(start1), .busy(busy1), .done(done1),
        .crd(crd1), .caddr_rd(caddr_rd1), .cdata_rd(cdata_rd1), .cwr(cwr1),
        .caddr_wr(caddr_wr1), .cdata_wr(cdata_wr1), .csel(csel1)
    );

    logic [DW-1:0] l1_0 [4096];
    logic [DW-1:0] l1_1 [4096];
    logic [DW-1:0] l2m  [4096];
    logic [DW-1:0] m1_l1[4096];
    logic [DW-1:0] m1_l2[4096];
    int wr_cnt = 0, act_cnt = 0, wr1_cnt = 0, act1_cnt = 0;

    // Shared memory port models: registered read, write on cwr with L2 select.
    always @(posedge clk) begin
        if (crd)
            cdata_rd <= (csel == 3'b011) ? l1_0[caddr_rd] :
                        (csel == 3'b100) ? l1_1[caddr_rd] : '0;
        if (cwr && csel == 3'b101) l2m[caddr_wr] <= cdata_wr;
        if (cwr) wr_cnt <= wr_cnt + 1;
        if (crd || cwr) act_cnt <= act_cnt + 1;
        if (crd1) cdata_rd1 <= (csel1 == 3'b011) ? m1_l1[caddr_rd1] : '0;
        if (cwr1 && csel1 == 3'b101) m1_l2[caddr_wr1] <= cdata_wr1;
        if (cwr1) wr1_cnt <= wr1_cnt + 1;
        if (crd1 || cwr1) act1_cnt <= act1_cnt + 1;
    end

    int n_cmp = 0;
    int n_fail = 0;
    int wr_exp = 0;

    function automatic void check(string nm, logic [63:0] act, logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h want %0h", nm, act, exp);
        end
    endfunction

    function automatic logic [63:0] outs0();
        return {busy, done, crd, cwr, csel, caddr_rd, caddr_wr, cdata_wr};
    endfunction

    // Bus protocol watch over both instances for the whole run.
    task automatic monitor();
        forever begin
            @(negedge clk);
            if (!busy) wr_exp = 0;
            if (crd || cwr) check("excl", 64'(crd & cwr), 0);
            if (cwr) begin
                check("wr_csel", 64'(csel), 64'(3'b101));
                check("wr_addr_seq", 64'(caddr_wr), 64'(wr_exp));
                wr_exp = int'(caddr_wr) + 1;
            end
            if (crd) check("rd_csel", 64'(csel == 3'b011 || csel == 3'b100), 1);
            if (crd1 || cwr1) check("excl1", 64'(crd1 & cwr1), 0);
            if (crd1) check("rd1_csel", 64'(csel1), 64'(3'b011));
            if (cwr1) check("wr1_csel", 64'(csel1), 64'(3'b101));
        end
    endtask

    // Reference: interleave the two L1 maps by plain index arithmetic.
    task automatic check_l2_image();
        logic [DW-1:0] expq[$];
        expq = {};
        for (int i = 0; i < 1024; i++) begin
            expq.push_back(l1_0[i]);
            expq.push_back(l1_1[i]);
        end
        for (int a = 0; a < 2048; a++) check("l2_image", 64'(l2m[a]), 64'(expq[a]));
    endtask

    // Pulse start, optionally re-pulse while busy; lat = edges from the
    // start-sampling edge to the edge that samples done high.
    task automatic run0(input bit repulse, output int lat);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        check("accept", 64'({busy, crd, csel, caddr_rd}), 64'({1'b1, 1'b1, 3'b011, 12'd0}));
        lat = 0;
        while (!done && lat < 7000) begin
            start = repulse && (lat == 50 || lat == 3000);
            @(negedge clk);
            lat++;
        end
        start = 1'b0;
        check("done_seen", 64'(done), 1);
        lat++;
        @(negedge clk);
        check("idle_after", 64'({busy, done}), 0);
    endtask

    typedef struct {
        int            addr;
        logic [DW-1:0] val;
    } vec_t;

    initial begin
        vec_t tbl[8];
        int   lat, w0, a0, n;
        tbl[0] = '{0,    20'h00000};
        tbl[1] = '{1,    20'h80000};
        tbl[2] = '{2,    20'h00001};
        tbl[3] = '{3,    20'h80001};
        tbl[4] = '{200,  20'h00064};
        tbl[5] = '{201,  20'h80064};
        tbl[6] = '{2046, 20'h003FF};
        tbl[7] = '{2047, 20'h803FF};

        fork monitor(); join_none

        // Reset state, then start held high with reset low.
        reset = 1'b0; start = 1'b0; start1 = 1'b0;
        @(negedge clk);
        @(negedge clk);
        check("reset_state", outs0(), 0);
        a0 = act_cnt;
        start = 1'b1;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            check("rst_vs_start", outs0(), 0);
        end
        reset = 1'b1; start = 1'b0;
        repeat (5) @(negedge clk);
        check("stay_idle", outs0(), 0);
        check("no_activity", 64'(act_cnt - a0), 0);

        // Deterministic full run with start re-pulsed while busy.
        for (int i = 0; i < 1024; i++) begin
            l1_0[i] = 20'(i);
            l1_1[i] = 20'h80000 | 20'(i);
        end
        w0 = wr_cnt;
        run0(1'b1, lat);
        check("latency", 64'(lat), 6145);
        check("wr_count", 64'(wr_cnt - w0), 2048);
        foreach (tbl[t]) check("tbl", 64'(l2m[tbl[t].addr]), 64'(tbl[t].val));
        check_l2_image();

        // Random data, reset during WR of idx=100 ch=1, then a clean rerun.
        for (int i = 0; i < 1024; i++) begin
            l1_0[i] = 20'($urandom);
            l1_1[i] = 20'($urandom);
        end
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        n = 0;
        while (!(cwr && caddr_wr == 12'd201) && n < 2000) begin
            @(negedge clk);
            n++;
        end
        check("mid_wr_found", 64'(cwr && caddr_wr == 12'd201), 1);
        reset = 1'b0;
        @(negedge clk);
        check("mid_reset", outs0(), 0);
        reset = 1'b1;
        @(negedge clk);
        check("post_reset_idle", outs0(), 0);
        for (int i = 0; i < 1024; i++) begin
            l1_0[i] = 20'($urandom);
            l1_1[i] = 20'($urandom) | 20'h80000;
        end
        l1_0[1023] = 20'hFFFFF;
        w0 = wr_cnt;
        run0(1'b0, lat);
        check("latency_rerun", 64'(lat), 6145);
        check("wr_count_rerun", 64'(wr_cnt - w0), 2048);
        check_l2_image();

        // Single-channel, 16-deep instance.
        for (int i = 0; i < 16; i++) m1_l1[i] = 20'hFFFFF - 20'(i);
        w0 = wr1_cnt;
        start1 = 1'b1;
        @(negedge clk);
        start1 = 1'b0;
        check("accept1", 64'(busy1), 1);
        lat = 0;
        while (!done1 && lat < 200) begin
            @(negedge clk);
            lat++;
        end
        check("done1_seen", 64'(done1), 1);
        check("latency1", 64'(lat + 1), 49);
        check("wr1_count", 64'(wr1_cnt - w0), 16);
        for (int i = 0; i < 16; i++)
            check("l2_n1", 64'(m1_l2[i]), 64'(20'hFFFFF - 20'(i)));
        @(negedge clk);
        check("idle1_after", 64'(busy1), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
